// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives key_exp through rounds 0..NR, buffers every
// round key, then serves single-cycle random-access reads (1-cycle read latency).
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key,
    output logic         ke_en,
    output logic [3:0]   ke_kcnt,
    output logic [127:0] ke_key,
    input  logic         ke_done,
    input  logic [127:0] ke_w,
    input  logic         rk_rd,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic         rk_err,
    output logic         busy,
    output logic         keys_ready
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_READY
    } state_t;

    state_t         r_state;
    logic           r_ke_en;
    logic [3:0]     r_ke_kcnt;
    logic [127:0]   r_ke_key;
    logic [3:0]     r_cap_cnt;
    logic [127:0]   r_buf [0:NR];
    logic           r_rk_valid;
    logic [127:0]   r_rk_data;
    logic           r_rk_err;
    logic           r_busy;
    logic           r_keys_ready;

    logic           w_cap;
    logic           w_rd_ok;
    logic           w_idx_bad;
    logic [127:0]   w_rd_data;

    // key_exp results arriving while idle (e.g. the tail of an aborted run) are dropped
    assign w_cap     = r_busy && ke_done && (r_cap_cnt <= NR_L);
    assign w_rd_ok   = rk_rd && r_keys_ready;
    assign w_idx_bad = (rk_idx > NR_L);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_idx == 4'(i)) begin
                w_rd_data = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ke_en      <= 1'b0;
            r_ke_kcnt    <= '0;
            r_ke_key     <= '0;
            r_cap_cnt    <= '0;
            r_rk_valid   <= 1'b0;
            r_rk_data    <= '0;
            r_rk_err     <= 1'b0;
            r_busy       <= 1'b0;
            r_keys_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // Reads use the pre-edge keys_ready, so a read alongside a restart still sees the old schedule
            r_rk_valid <= w_rd_ok;
            r_rk_err   <= w_rd_ok && w_idx_bad;
            r_rk_data  <= (w_rd_ok && !w_idx_bad) ? w_rd_data : '0;

            if (w_cap) begin
                for (int i = 0; i <= NR; i++) begin
                    if (r_cap_cnt == 4'(i)) begin
                        r_buf[i] <= ke_w;
                    end
                end
                r_cap_cnt <= r_cap_cnt + 4'd1;
            end

            case (r_state)
                S_IDLE, S_READY: begin
                    if (start && !abort) begin
                        r_ke_key     <= key;
                        r_ke_en      <= 1'b1;
                        r_ke_kcnt    <= '0;
                        r_cap_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_keys_ready <= 1'b0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        r_ke_en      <= 1'b0;
                        r_ke_kcnt    <= '0;
                        r_cap_cnt    <= '0;
                        r_busy       <= 1'b0;
                        r_keys_ready <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_ke_kcnt == NR_L) begin
                        r_ke_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_ke_kcnt <= r_ke_kcnt + 4'd1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_ke_en      <= 1'b0;
                        r_ke_kcnt    <= '0;
                        r_cap_cnt    <= '0;
                        r_busy       <= 1'b0;
                        r_keys_ready <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_cap && (r_cap_cnt == NR_L)) begin
                        r_busy       <= 1'b0;
                        r_keys_ready <= 1'b1;
                        r_state      <= S_READY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ke_en      = r_ke_en;
    assign ke_kcnt    = r_ke_kcnt;
    assign ke_key     = r_ke_key;
    assign rk_valid   = r_rk_valid;
    assign rk_data    = r_rk_data;
    assign rk_err     = r_rk_err;
    assign busy       = r_busy;
    assign keys_ready = r_keys_ready;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural one-cycle key_exp model.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] K0_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [127:0] key;
    logic         ke_en;
    logic [3:0]   ke_kcnt;
    logic [127:0] ke_key;
    logic         ke_done;
    logic [127:0] ke_w;
    logic         rk_rd;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;
    logic         busy;
    logic         keys_ready;

    int n_chk = 0;
    int n_err = 0;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
        .ke_en(ke_en), .ke_kcnt(ke_kcnt), .ke_key(ke_key),
        .ke_done(ke_done), .ke_w(ke_w),
        .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
        .rk_err(rk_err), .busy(busy), .keys_ready(keys_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] base = x;
        for (int e = 254; e != 0; e = e >> 1) begin
            if (e[0]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int rnd);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 1; i <= rnd; i++) begin
            t = {w3[23:0], w3[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            t = t ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = xt(rc);
        end
        return {w0, w1, w2, w3};
    endfunction

    // key_exp stand-in: registers the round key selected by kcnt one cycle after en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ke_done <= 1'b0;
            ke_w    <= '0;
        end else begin
            ke_done <= ke_en;
            ke_w    <= ke_en ? round_key(ke_key, int'(ke_kcnt)) : '0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then runs until keys_ready (bounded), checking the issue sequence
    task automatic run_exp(input logic [127:0] k, input int restart_at,
                           output int lat, output bit seq_ok, output bit rd_seen);
        seq_ok  = 1'b1;
        rd_seen = 1'b0;
        lat     = -1;
        key     = k;
        start   = 1'b1;
        tick();
        start = 1'b0;
        if (!(ke_en === 1'b1 && ke_kcnt === 4'd0 && busy === 1'b1 && keys_ready === 1'b0))
            seq_ok = 1'b0;
        rk_rd  = 1'b1;
        rk_idx = 4'd0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = 1'b0;
            key   = k;
            if (rk_valid !== 1'b0) rd_seen = 1'b1;
            if (c <= 10 && !(ke_kcnt === 4'(c) && ke_en === 1'b1 && busy === 1'b1)) seq_ok = 1'b0;
            if (c == 11 && ke_en !== 1'b0) seq_ok = 1'b0;
            if (keys_ready === 1'b1) begin
                lat = c;
                break;
            end
            if (c == restart_at) begin
                start = 1'b1;
                key   = ~k;
            end
        end
        rk_rd = 1'b0;
    endtask

    int lat;
    bit seq_ok;
    bit rd_seen;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        key    = '0;
        rk_rd  = 1'b0;
        rk_idx = '0;
        repeat (3) tick();
        chk("rst_outs", 128'({ke_en, ke_kcnt, busy, keys_ready, rk_valid, rk_err}), 128'd0);
        chk("rst_key", ke_key, 128'd0);
        rst_n = 1'b1;
        tick();

        run_exp(K1, -1, lat, seq_ok, rd_seen);
        chk("seq1", 128'(seq_ok), 128'd1);
        chk("lat1", 128'(lat), 128'd12);
        chk("rd_busy", 128'(rd_seen), 128'd0);
        chk("busy_done", 128'(busy), 128'd0);

        rk_rd = 1'b1; rk_idx = 4'd0;  tick();
        chk("rd0_v", 128'({rk_valid, rk_err}), 128'b10);
        chk("rd0_d", rk_data, K1);
        rk_idx = 4'd1; tick();
        chk("rd1_v", 128'({rk_valid, rk_err}), 128'b10);
        chk("rd1_d", rk_data, K1_R1);
        rk_idx = 4'd10; tick();
        chk("rd10_v", 128'({rk_valid, rk_err}), 128'b10);
        chk("rd10_d", rk_data, K1_R10);
        rk_idx = 4'd11; tick();
        chk("rd11_v", 128'({rk_valid, rk_err}), 128'b11);
        chk("rd11_d", rk_data, 128'd0);
        rk_idx = 4'd15; tick();
        chk("rd15_v", 128'({rk_valid, rk_err}), 128'b11);
        chk("rd15_d", rk_data, 128'd0);
        for (int i = 2; i <= 9; i++) begin
            rk_idx = 4'(i); tick();
            chk($sformatf("rdall%0d", i), rk_data, round_key(K1, i));
        end
        rk_rd = 1'b0; tick();
        chk("rd_idle", 128'(rk_valid), 128'd0);

        run_exp(K1, 5, lat, seq_ok, rd_seen);
        chk("ign_seq", 128'(seq_ok), 128'd1);
        chk("ign_lat", 128'(lat), 128'd12);
        chk("ign_key", ke_key, K1);
        rk_rd = 1'b1; rk_idx = 4'd10; tick(); rk_rd = 1'b0;
        chk("ign_r10", rk_data, K1_R10);

        key = 128'hffff; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("ab_kcnt4", 128'(ke_kcnt), 128'd4);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_outs", 128'({ke_en, busy, keys_ready}), 128'd0);
        chk("ab_kcnt", 128'(ke_kcnt), 128'd0);
        rk_rd = 1'b1; rk_idx = 4'd0;
        repeat (3) tick();
        chk("ab_idle", 128'({ke_en, busy, keys_ready, rk_valid}), 128'd0);
        rk_rd = 1'b0;

        run_exp(128'd0, -1, lat, seq_ok, rd_seen);
        chk("k0_seq", 128'(seq_ok), 128'd1);
        chk("k0_lat", 128'(lat), 128'd12);
        rk_rd = 1'b1; rk_idx = 4'd10; tick(); rk_rd = 1'b0;
        chk("k0_r10", rk_data, K0_R10);

        rk_rd = 1'b1; rk_idx = 4'd10; start = 1'b1; key = K1;
        tick();
        rk_rd = 1'b0; start = 1'b0;
        chk("rs_v", 128'({rk_valid, rk_err}), 128'b10);
        chk("rs_d", rk_data, K0_R10);
        chk("rs_flags", 128'({keys_ready, busy}), 128'b01);

        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", 128'({ke_en, ke_kcnt, busy, keys_ready, rk_valid, rk_err}), 128'd0);
        chk("arst_key", ke_key, 128'd0);
        chk("arst_data", rk_data, 128'd0);
        tick();
        rst_n = 1'b1;
        rk_rd = 1'b1; rk_idx = 4'd0;
        tick(); tick();
        rk_rd = 1'b0;
        chk("post_rst", 128'({keys_ready, rk_valid, busy}), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
